// File: rtl/display_scanner.sv
// Multiplexed hex display scanner: per-digit time slots, frame-wide snapshot, 16-step PWM dimming.
// Optional macro LEADING_ZERO_BLANK_EN darkens digits above the most significant nonzero nibble.
module display_scanner #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   cathode,
  output logic [7:0]              segmentout,
  output logic                    frame_start
);

  localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [PW-1:0]           pre;
  logic [IW-1:0]           idx;
  logic [3:0]              pwm;
  logic [4*NUM_DIGITS-1:0] snap_data;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;

  logic                    pre_wrap;
  logic                    frame_wrap;
  logic [3:0]              nib;
  logic                    cur_dp;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   cathode_d;
  logic [7:0]              segment_d;
  logic                    frame_start_d;

  // Active-low {dp,g,f,e,d,c,b,a} with the dp segment off.
  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 8'hC0;
      4'h1: hex_seg = 8'hF9;
      4'h2: hex_seg = 8'hA4;
      4'h3: hex_seg = 8'hB0;
      4'h4: hex_seg = 8'h99;
      4'h5: hex_seg = 8'h92;
      4'h6: hex_seg = 8'h82;
      4'h7: hex_seg = 8'hF8;
      4'h8: hex_seg = 8'h80;
      4'h9: hex_seg = 8'h90;
      4'hA: hex_seg = 8'h88;
      4'hB: hex_seg = 8'h83;
      4'hC: hex_seg = 8'hC6;
      4'hD: hex_seg = 8'hA1;
      4'hE: hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  assign pre_wrap   = (pre == PW'(REFRESH_DIV - 1));
  assign frame_wrap = pre_wrap && (idx == IW'(NUM_DIGITS - 1));

  // Slot timing, PWM phase and the frame snapshot (loaded as idx wraps to 0).
  always_ff @(posedge clk) begin
    if (rst) begin
      pre        <= '0;
      idx        <= '0;
      pwm        <= '0;
      snap_data  <= '0;
      snap_dp    <= '0;
      snap_blank <= '1;
    end else begin
      pwm <= pwm + 4'd1;
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) begin
        idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end
      if (frame_wrap) begin
        snap_data  <= data;
        snap_dp    <= dp;
        snap_blank <= blank;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] lz_top;

  // Index of the most significant nonzero snapshot nibble; 0 when all are zero.
  always_comb begin
    lz_top = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (snap_data[4*i +: 4] != 4'h0) lz_top = IW'(i);
    end
  end
`endif

  always_comb begin
    nib           = snap_data[4*idx +: 4];
    cur_dp        = snap_dp[idx];
    lit           = (pwm <= brightness) && !snap_blank[idx];
    segment_d     = hex_seg(nib) & {~cur_dp, 7'h7F};
    frame_start_d = (pre == '0) && (idx == '0);
`ifdef LEADING_ZERO_BLANK_EN
    // Suppressed leading digit keeps only a requested decimal point.
    if (idx > lz_top) begin
      if (cur_dp) segment_d = 8'h7F;
      else        lit = 1'b0;
    end
`endif
    cathode_d = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    if (!lit) segment_d = 8'hFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cathode     <= '1;
      segmentout  <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      cathode     <= cathode_d;
      segmentout  <= segment_d;
      frame_start <= frame_start_d;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (NUM_DIGITS=4, REFRESH_DIV=4): directed and random steps against a
// cycle-count reference model; define LEADING_ZERO_BLANK_EN to check the suppression variant.
module tb_display_scanner;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;

  logic        clk;
  logic        rst;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic [3:0]  brightness;
  logic [3:0]  cathode;
  logic [7:0]  segmentout;
  logic        frame_start;

  int tests;
  int fails;
  int k;
  int on_cnt;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  m_blank;
  logic [3:0]  e_cath;
  logic [7:0]  e_seg;
  logic        e_fs;

  display_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .blank(blank), .brightness(brightness),
    .cathode(cathode), .segmentout(segmentout), .frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] hex7(input logic [3:0] v);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[v];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h k=%0d", tag, obs, exp, k);
    end
  endtask

  // Expected outputs after this edge; k counts edges since reset release.
  task automatic model_edge();
    int s, d, top;
    logic lit, dpc;
    if (rst) begin
      k = 0; m_data = '0; m_dp = '0; m_blank = 4'hF;
      e_cath = 4'hF; e_seg = 8'hFF; e_fs = 1'b0;
      return;
    end
    k++;
    s   = k - 1;
    d   = (s / RD) % ND;
    dpc = m_dp[d];
    lit = ((s % 16) <= int'(brightness)) && !m_blank[d];
    e_seg = hex7(m_data[4*d +: 4]);
    if (dpc) e_seg[7] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    top = 0;
    for (int i = 0; i < ND; i++) if (m_data[4*i +: 4] != 4'h0) top = i;
    if (d > top) begin
      if (dpc) e_seg = 8'h7F;
      else     lit = 1'b0;
    end
`else
    top = 0;
`endif
    e_cath = lit ? ~(4'b0001 << d) : 4'hF;
    if (!lit) e_seg = 8'hFF;
    e_fs = ((s % FR) == 0);
    if ((k % FR) == 0) begin
      m_data = data; m_dp = dp; m_blank = blank;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cathode", 8'(cathode), 8'(e_cath));
    check("segmentout", segmentout, e_seg);
    check("frame_start", 8'(frame_start), 8'(e_fs));
    tests++;
    assert ($countones(~cathode) <= 1) else begin
      fails++;
      $error("FAIL onehot observed=%b expected=at_most_one_low k=%0d", cathode, k);
    end
    if (cathode != 4'hF) on_cnt++;
  endtask

  task automatic align_frame();
    int n;
    n = 0;
    while ((k % FR) != 0 && n < 2 * FR) begin
      step();
      n++;
    end
    check("align_bound", 8'((k % FR) == 0), 8'd1);
  endtask

  initial begin
    tests = 0; fails = 0; k = 0; on_cnt = 0;
    rst = 1'b1; data = '0; dp = '0; blank = '0; brightness = 4'd15;
    repeat (3) step();
    check("reset_cathode", 8'(cathode), 8'h0F);
    check("reset_seg", segmentout, 8'hFF);

    // Frame 1 dark, frame 2 shows 3210; a mid-frame-2 change lands in frame 3.
    rst = 1'b0; data = 16'h3210;
    step();
    check("fs_first_release", 8'(frame_start), 8'd1);
    repeat (23) step();
    data = 16'h7654;
    repeat (24) step();

    brightness = 4'd7;
    align_frame();
    on_cnt = 0;
    repeat (FR) step();
    check("on_count_b7", 8'(on_cnt), 8'd8);
    brightness = 4'd0;
    on_cnt = 0;
    repeat (FR) step();
    check("on_count_b0", 8'(on_cnt), 8'd1);
    brightness = 4'd15;

    blank = 4'b0100; dp = 4'b0001;
    repeat (40) step();

    blank = '0; dp = '0; data = 16'h0050;
    repeat (32) step();
    data = 16'h0000;
    repeat (32) step();
    dp = 4'b1000;
    repeat (32) step();

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: data = 16'($urandom);
          1: dp = 4'($urandom);
          2: blank = 4'($urandom) & 4'($urandom);
          default: brightness = 4'($urandom);
        endcase
      end
      step();
    end

    // One-clock reset in the middle of digit 2's slot.
    begin
      int n;
      n = 0;
      while (!(((k / RD) % ND) == 2 && (k % RD) == 2) && n < 2 * FR) begin
        step();
        n++;
      end
      check("midslot_bound", 8'(((k / RD) % ND) == 2), 8'd1);
    end
    rst = 1'b1;
    step();
    check("midrst_cathode", 8'(cathode), 8'h0F);
    check("midrst_seg", segmentout, 8'hFF);
    rst = 1'b0;
    step();
    check("midrst_fs", 8'(frame_start), 8'd1);
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
